// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control blocks.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    JUMP    = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam int ADDR_W  = 16;
  localparam int CAUSE_W = 3;
  localparam logic [ADDR_W-1:0] VEC_BASE_DEFAULT = 16'h0010;

  // Vector for a line: base plus zero-extended cause, wrapping at the address width.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [CAUSE_W-1:0] cause);
    return base + {{(ADDR_W-CAUSE_W){1'b0}}, cause};
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer: edge-latched requests, prioritised take at instruction
// boundaries, return-address push handshake and a one-cycle vector jump.
module int_ctrl
  import cpu_pkg::*;
#(
  parameter int                NIRQ     = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NIRQ-1:0]     IRQ,
  input  logic                IE,
  input  logic [NIRQ-1:0]     MASK,
  input  logic                INSTR_DONE,
  input  logic                RETI,
  input  logic                PUSH_ACK,
  output logic                PUSH_REQ,
  output logic                INTjmp,
  output logic [ADDR_W-1:0]   Aint,
  output logic                ACTIVE,
  output logic [CAUSE_W-1:0]  CAUSE
);

  state_t              state, state_next;
  logic [NIRQ-1:0]     irq_q;
  logic [NIRQ-1:0]     pend, pend_next;
  logic [NIRQ-1:0]     eligible, take_mask;
  logic [CAUSE_W-1:0]  win_idx;
  logic                win_valid;
  logic                push_req_next, intjmp_next, active_next;
  logic [ADDR_W-1:0]   aint_next;
  logic [CAUSE_W-1:0]  cause_next;

  assign eligible = IE ? (pend & MASK) : '0;

  prio_enc #(.N(NIRQ), .W(CAUSE_W)) u_prio (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_next    = state;
    push_req_next = PUSH_REQ;
    intjmp_next   = 1'b0;
    aint_next     = '0;
    active_next   = ACTIVE;
    cause_next    = CAUSE;
    take_mask     = '0;
    case (state)
      IDLE: begin
        if (win_valid && INSTR_DONE) begin
          take_mask     = NIRQ'(1) << win_idx;
          cause_next    = win_idx;
          push_req_next = 1'b1;
          state_next    = PUSH;
        end
      end
      PUSH: begin
        // An ack only counts while our request is visible on the port.
        if (PUSH_ACK && PUSH_REQ) begin
          push_req_next = 1'b0;
          intjmp_next   = 1'b1;
          aint_next     = vec_addr(VEC_BASE, CAUSE);
          state_next    = JUMP;
        end
      end
      JUMP: begin
        active_next = 1'b1;
        state_next  = SERVICE;
      end
      SERVICE: begin
        if (RETI) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A fresh edge in the take cycle re-pends the line.
    pend_next = (pend & ~take_mask) | (IRQ & ~irq_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      irq_q    <= '0;
      pend     <= '0;
      PUSH_REQ <= 1'b0;
      INTjmp   <= 1'b0;
      Aint     <= '0;
      ACTIVE   <= 1'b0;
      CAUSE    <= '0;
    end else begin
      state    <= state_next;
      irq_q    <= IRQ;
      pend     <= pend_next;
      PUSH_REQ <= push_req_next;
      INTjmp   <= intjmp_next;
      Aint     <= aint_next;
      ACTIVE   <= active_next;
      CAUSE    <= cause_next;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed and random stimulus against a transaction-level
// reference, with a scoreboard of expected vector takes.
module tb_int_ctrl;

  localparam logic [15:0] VB = 16'h0010;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  IRQ = '0;
  logic        IE = 1'b1;
  logic [3:0]  MASK = 4'hF;
  logic        INSTR_DONE = 1'b0;
  logic        RETI = 1'b0;
  logic        PUSH_ACK = 1'b0;
  logic        PUSH_REQ, INTjmp, ACTIVE;
  logic [15:0] Aint;
  logic [2:0]  CAUSE;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(.NIRQ(4), .VEC_BASE(VB)) dut (
    .CLK(CLK), .RST(RST), .IRQ(IRQ), .IE(IE), .MASK(MASK),
    .INSTR_DONE(INSTR_DONE), .RETI(RETI), .PUSH_ACK(PUSH_ACK),
    .PUSH_REQ(PUSH_REQ), .INTjmp(INTjmp), .Aint(Aint),
    .ACTIVE(ACTIVE), .CAUSE(CAUSE)
  );

  always #5 CLK = ~CLK;

  // Reference: which lines are pending, and how far along the current
  // service sequence is (0 idle, 1 awaiting stack, 2 vector cycle, 3 in handler).
  bit [3:0] m_pend = '0;
  bit [3:0] m_prev = '0;
  int       m_step = 0;
  int       m_cause = 0;
  bit       m_was_reset = 1'b0;
  int       exp_q[$];

  always @(posedge CLK) begin
    int       win;
    bit [3:0] nxt;
    win = -1;
    nxt = m_pend;
    if (!RST) begin
      m_pend <= '0;
      m_prev <= '0;
      m_step <= 0;
      m_cause <= 0;
      m_was_reset <= 1'b1;
      exp_q.delete();
    end else begin
      m_was_reset <= 1'b0;
      if (m_step == 0 && INSTR_DONE && IE)
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && MASK[i]) win = i;
      if (win >= 0) nxt[win] = 1'b0;
      nxt = nxt | (IRQ & ~m_prev);
      m_pend <= nxt;
      m_prev <= IRQ;
      case (m_step)
        0: if (win >= 0) begin
             m_step <= 1;
             m_cause <= win;
             exp_q.push_back(win);
           end
        1: if (PUSH_ACK) m_step <= 2;
        2: m_step <= 3;
        default: if (RETI) m_step <= 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle output checks; pops the scoreboard on each vector jump.
  initial begin
    int e;
    forever begin
      @(negedge CLK);
      check("push_req", 32'(PUSH_REQ), 32'(m_step == 1));
      check("intjmp",   32'(INTjmp),   32'(m_step == 2));
      check("active",   32'(ACTIVE),   32'(m_step == 3));
      check("cause",    32'(CAUSE),    32'(m_cause));
      check("pend",     32'(dut.pend), 32'(m_pend));
      if (m_was_reset) check("aint_reset", 32'(Aint), 32'h0);
      if (INTjmp === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL take: INTjmp with no expected request, Aint=%h", Aint);
        end else begin
          e = exp_q.pop_front();
          check("aint", 32'(Aint), 32'(VB + 16'(e)));
          check("cause_at_jump", 32'(CAUSE), 32'(e));
          $display("take line %0d vector %h", CAUSE, Aint);
        end
      end
    end
  end

  task automatic cyc(input bit rst_n, input bit [3:0] irq, input bit ie, input bit [3:0] mask,
                     input bit done, input bit reti, input bit ack);
    @(negedge CLK);
    RST = rst_n; IRQ = irq; IE = ie; MASK = mask;
    INSTR_DONE = done; RETI = reti; PUSH_ACK = ack;
  endtask

  initial begin
    bit [3:0] r_irq;
    bit [3:0] r_mask;
    repeat (3) cyc(0, 4'h0, 1, 4'hF, 0, 0, 0);
    // single request on line 2 with a 5-cycle stack stall
    cyc(1, 4'b0100, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0100, 1, 4'hF, 1, 0, 0);
    repeat (5) cyc(1, 4'b0100, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0100, 1, 4'hF, 0, 0, 1);
    repeat (3) cyc(1, 4'b0100, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0100, 1, 4'hF, 0, 1, 0);
    // priority: lines 3 and 1 together; line 0 rises while in service
    cyc(1, 4'b1110, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b1110, 1, 4'hF, 1, 0, 0);
    cyc(1, 4'b1110, 1, 4'hF, 0, 0, 1);
    repeat (2) cyc(1, 4'b1110, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b1111, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b1111, 1, 4'hF, 1, 0, 0);
    cyc(1, 4'b1111, 1, 4'hF, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 4'b1111, 1, 4'hF, 1, 0, 0);
      cyc(1, 4'b1111, 1, 4'hF, 0, 0, 1);
      repeat (2) cyc(1, 4'b1111, 1, 4'hF, 0, 0, 0);
      cyc(1, 4'b1111, 1, 4'hF, 0, 1, 0);
    end
    // gating by IE, then by MASK
    for (int k = 0; k < 2; k++) begin
      cyc(1, 4'b0000, 1, 4'hF, 0, 0, 0);
      cyc(1, 4'b0001, k != 0, (k != 0) ? 4'hE : 4'hF, 0, 0, 0);
      repeat (3) cyc(1, 4'b0001, k != 0, (k != 0) ? 4'hE : 4'hF, 1, 0, 0);
      cyc(1, 4'b0001, 1, 4'hF, 1, 0, 0);
      cyc(1, 4'b0001, 1, 4'hF, 0, 0, 1);
      repeat (2) cyc(1, 4'b0001, 1, 4'hF, 0, 0, 0);
      cyc(1, 4'b0001, 1, 4'hF, 0, 1, 0);
    end
    // set wins: line 1 re-edges in the cycle it is taken
    cyc(1, 4'b0010, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0000, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0010, 1, 4'hF, 1, 0, 0);
    cyc(1, 4'b0010, 1, 4'hF, 0, 0, 1);
    repeat (2) cyc(1, 4'b0010, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0010, 1, 4'hF, 0, 1, 0);
    cyc(1, 4'b0010, 1, 4'hF, 1, 0, 0);
    cyc(1, 4'b0010, 1, 4'hF, 0, 0, 1);
    cyc(1, 4'b0010, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0010, 1, 4'hF, 0, 1, 0);
    // spurious RETI and ack in idle
    cyc(1, 4'b0010, 1, 4'hF, 0, 1, 0);
    cyc(1, 4'b0010, 1, 4'hF, 0, 0, 1);
    // reset while waiting on the stack, with an ack in the same cycle
    cyc(1, 4'b0110, 1, 4'hF, 0, 0, 0);
    cyc(1, 4'b0110, 1, 4'hF, 1, 0, 0);
    cyc(1, 4'b0110, 1, 4'hF, 0, 0, 0);
    cyc(0, 4'b0110, 1, 4'hF, 0, 0, 1);
    repeat (2) cyc(1, 4'b0000, 1, 4'hF, 0, 0, 0);
    // random traffic
    r_irq = '0;
    r_mask = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      r_irq = r_irq ^ 4'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) r_mask = 4'($urandom);
      cyc(($urandom_range(0, 199) != 0), r_irq, ($urandom_range(0, 7) != 0), r_mask,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    // drain any sequence still in flight
    repeat (10) cyc(1, r_irq, 1, 4'hF, 0, 1, 1);
    @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt sequencer for the program counter. It latches edge-triggered requests, picks the highest-priority unmasked one at an instruction boundary, and saves the return address through the stack handshake. It then drives the PC's interrupt-jump control and vector address for exactly one cycle. It sits between the peripheral IRQ lines, the control sequencer and the PC/stack datapath.

## Interface
- NIRQ, 4, number of interrupt lines (1..8); line 0 has the highest priority
- VEC_BASE, 16'h0010, vector address for line 0; line i vectors to VEC_BASE + i
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-low
- IRQ  in  NIRQ  level request lines from peripherals; a rising edge pends a request
- IE  in  1  global interrupt enable from the status register
- MASK  in  NIRQ  per-line enable; 1 = line eligible
- INSTR_DONE  in  1  one-cycle pulse from the sequencer at each instruction boundary
- RETI  in  1  one-cycle pulse when return-from-interrupt is decoded
- PUSH_ACK  in  1  stack has stored the current PC
- PUSH_REQ  out  1  request to push the current PC onto the return stack
- INTjmp  out  1  one-cycle pulse that loads Aint into the PC
- Aint  out  16  vector address; valid while INTjmp = 1
- ACTIVE  out  1  a handler is in service
- CAUSE  out  3  index of the line currently in service

## Operation
- Edge detect: an internal register holds the IRQ value from the previous cycle. `IRQ & ~irq_q` sets the corresponding bits of `pend`.
- Pending bits persist regardless of IE or MASK.
- A bit of `pend` is cleared only when its line is taken. If a new edge arrives in the same cycle the line is taken, the set wins and the bit stays pending.
- eligible = `pend & MASK`, gated by IE. The winner is the lowest index that is eligible.
- FSM states:
  - IDLE: the eligible set is non-empty and INSTR_DONE = 1 → latch the winner into CAUSE, clear its pend bit, assert PUSH_REQ, go to PUSH.
  - PUSH: PUSH_REQ is held high until PUSH_ACK = 1. Then drop PUSH_REQ, go to JUMP.
  - JUMP: INTjmp = 1 and Aint = VEC_BASE + CAUSE for this single cycle. Then set ACTIVE and go to SERVICE.
  - SERVICE: RETI = 1 → clear ACTIVE, go to IDLE. The PC's own Ret path restores the address.
- Nesting is not supported. New edges are pended during PUSH, JUMP and SERVICE, but no line is taken until the block is back in IDLE.
- RETI outside SERVICE is ignored.
- INSTR_DONE without an eligible request has no effect.
- Aint width rule: VEC_BASE + CAUSE is computed modulo 2^16, with CAUSE zero-extended.

## Timing
- Reset values: PUSH_REQ = 0, INTjmp = 0, Aint = 16'h0000, ACTIVE = 0, CAUSE = 0, `pend` = 0, `irq_q` = 0, state IDLE.
- Reset mid-sequence, including during PUSH with an ack outstanding, abandons the sequence and returns to the reset values.
- All outputs are registered.
- Latency:
  - Edge to pend: 1 cycle.
  - INSTR_DONE to PUSH_REQ high: 1 cycle.
  - PUSH_ACK to INTjmp: 1 cycle.
  - INTjmp to ACTIVE: 1 cycle.
  - RETI to ACTIVE low: 1 cycle.
- INTjmp is stable for a full CLK period, so the PC samples it on the intervening falling edge.
- INTjmp is never asserted while PUSH_REQ is high.
- Only a PUSH_ACK that arrives while PUSH_REQ is high is honoured.
- Minimum IDLE-to-IDLE sequence length: 4 cycles (PUSH, JUMP, SERVICE, RETI).
- A request that is eligible on the same cycle that RETI returns the block to IDLE waits for the next INSTR_DONE.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum (IDLE, PUSH, JUMP, SERVICE).
  - Default VEC_BASE constant.
  - Address width constant (16).
- One natural sub-module: `prio_enc`, a parameterised lowest-index-first encoder that outputs the index and a valid flag.
- The edge detect, pend register and FSM stay in the top module.

## Test plan
- Single request:
  - Stimulus: reset with RST = 0, then release. IE = 1, MASK = 4'hF. IRQ[2] rises, then INSTR_DONE pulses.
  - Required response: PUSH_REQ rises 1 cycle after INSTR_DONE. After PUSH_ACK, INTjmp = 1 for exactly one cycle with Aint = 16'h0012. ACTIVE = 1 and CAUSE = 2. RETI clears ACTIVE.
- Priority:
  - Stimulus: IRQ[3] and IRQ[1] rise in the same cycle, then INSTR_DONE.
  - Required response: line 1 is taken first (Aint = 16'h0011) and pend[3] remains set. After RETI plus the next INSTR_DONE, line 3 is taken (Aint = 16'h0013).
- Gating:
  - Stimulus: IE = 0, IRQ[0] rises, several INSTR_DONE pulses. Then IE = 1 and INSTR_DONE.
  - Required response: no PUSH_REQ while IE = 0; line 0 is taken after IE = 1.
  - Repeat with MASK[0] = 0 in place of IE = 0; same result.
- No nesting and set-wins:
  - Stimulus: during SERVICE, IRQ[0] rises. Separately, an edge on a line coincides with the cycle that line is taken.
  - Required response: the IRQ[0] edge raises no PUSH_REQ until after RETI. In the set-wins case the pend bit stays 1.
- Handshake stall and reset:
  - Stimulus: hold PUSH_ACK low for 5 cycles, then assert it.
  - Required response: PUSH_REQ stays high for all 5 cycles and INTjmp follows 1 cycle after the ack.
  - Stimulus: assert RST = 0 during PUSH.
  - Required response: all outputs return to their reset values on the next edge, and `pend` is cleared.
- Spurious inputs:
  - Stimulus: RETI in IDLE; PUSH_ACK with no request outstanding.
  - Required response: no state change and no output activity.
